// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_pkg
//  Description : Shared encodings for the EX stage with iterative mul/div:
//                ALU / MD / memory opcodes, exception codes, MD FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_AND  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_ADDS = 4'd4,
        ALU_ADDU = 4'd5,
        ALU_SUBS = 4'd6,
        ALU_SUBU = 4'd7,
        ALU_SHRL = 4'd8,
        ALU_SHLL = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MUL   = 3'd1,
        MD_MULHU = 3'd2,
        MD_DIVU  = 3'd3,
        MD_REMU  = 3'd4
    } md_op_e;

    typedef enum logic [1:0] {
        MEM_NOP = 2'd0,
        MEM_LDW = 2'd1,
        MEM_STW = 2'd2
    } mem_op_e;

    typedef enum logic [2:0] {
        EXP_NONE       = 3'd0,
        EXP_UNDEF_INSN = 3'd1,
        EXP_OVERFLOW   = 3'd2,
        EXP_MISS_ALIGN = 3'd3,
        EXP_TRAP       = 3'd4,
        EXP_PRV_VIO    = 3'd5
    } exp_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Codes 1..4 are real mul/div operations; everything else is not.
    function automatic logic md_op_valid(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv
//  Description : Iterative unsigned multiplier / restoring divider, one bit
//                per cycle. Shares one hi/lo register pair: for multiply
//                hi=partial product, lo=multiplier; for divide hi=remainder,
//                lo=dividend shifting into quotient.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  md_op_e        i_op,
    input  logic [DW-1:0] i_opa,
    input  logic [DW-1:0] i_opb,
    input  logic          i_abort,
    input  logic          i_ack,
    output logic          o_busy,
    output logic          o_done,
    output logic [DW-1:0] o_result
);

    localparam int            c_CW       = $clog2(DW);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DW - 1);

    md_state_e       r_state;
    md_state_e       w_nstate;
    md_op_e          r_op;
    logic [c_CW-1:0] r_cnt;
    logic [DW-1:0]   r_hi;
    logic [DW-1:0]   r_lo;
    logic [DW-1:0]   r_opb;

    logic            w_div0;
    logic            w_is_mul;
    logic [DW:0]     w_mac;
    logic [DW:0]     w_rsh;
    logic            w_ge;
    logic [DW-1:0]   w_rdiff;

    assign w_div0   = ((i_op == MD_DIVU) || (i_op == MD_REMU)) && (i_opb == '0);
    assign w_is_mul = (r_op == MD_MUL) || (r_op == MD_MULHU);

    // Multiply step: conditionally add multiplicand, carry kept for the shift.
    assign w_mac   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    // Divide step: shift next dividend bit into the remainder and trial-subtract.
    // The difference fits DW bits whenever it is kept (remainder < divisor).
    assign w_rsh   = {r_hi, r_lo[DW-1]};
    assign w_ge    = (w_rsh >= {1'b0, r_opb});
    assign w_rdiff = w_rsh[DW-1:0] - r_opb;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nstate;
    end

    // Next-state logic; abort wins from any state, divide-by-zero skips BUSY
    always_comb begin
        w_nstate = r_state;
        if (i_abort) begin
            w_nstate = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start) w_nstate = w_div0 ? ST_DONE : ST_BUSY;
                ST_BUSY: if (r_cnt == c_CNT_LAST) w_nstate = ST_DONE;
                ST_DONE: if (i_ack) w_nstate = ST_IDLE;
                default: w_nstate = ST_IDLE;
            endcase
        end
    end

    // Outputs: status flags and the half of hi/lo selected by the operation
    always_comb begin
        o_busy = (r_state == ST_BUSY);
        o_done = (r_state == ST_DONE);
        case (r_op)
            MD_MULHU, MD_REMU: o_result = r_hi;
            default:           o_result = r_lo;
        endcase
    end

    // Operand capture and one iteration per BUSY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= MD_NONE;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_opb <= '0;
        end else if (i_abort) begin
            r_op  <= MD_NONE;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_opb <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_op  <= i_op;
                        r_cnt <= '0;
                        if (w_div0) begin
                            r_hi  <= i_opa;
                            r_lo  <= '1;
                            r_opb <= '0;
                        end else if ((i_op == MD_MUL) || (i_op == MD_MULHU)) begin
                            r_hi  <= '0;
                            r_lo  <= i_opb;
                            r_opb <= i_opa;
                        end else begin
                            r_hi  <= '0;
                            r_lo  <= i_opa;
                            r_opb <= i_opb;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
                    if (w_is_mul) begin
                        r_hi <= w_mac[DW:1];
                        r_lo <= {w_mac[0], r_lo[DW-1:1]};
                    end else begin
                        r_hi <= w_ge ? w_rdiff : w_rsh[DW-1:0];
                        r_lo <= {r_lo[DW-2:0], w_ge};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage_md.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_md
//  Description : Pipeline EX stage: single-cycle ALU, iterative mul/div unit,
//                EX pipeline register and same-cycle forwarding path.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_md
    import ex_pkg::*;
#(
    parameter int DW  = 32,
    parameter int PCW = 30,
    parameter int GAW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           flush,
    input  logic           int_detect,
    output logic           md_busy,
    input  logic           id_en,
    input  logic [PCW-1:0] id_pc,
    input  logic [3:0]     id_alu_op,
    input  logic [2:0]     id_md_op,
    input  logic [DW-1:0]  id_alu_in_0,
    input  logic [DW-1:0]  id_alu_in_1,
    input  logic [GAW-1:0] id_dst_addr,
    input  logic           id_gpr_we_,
    input  logic [1:0]     id_mem_op,
    input  logic [DW-1:0]  id_mem_wr_data,
    input  logic           id_br_flag,
    output logic           ex_en,
    output logic [PCW-1:0] ex_pc,
    output logic [GAW-1:0] ex_dst_addr,
    output logic           ex_gpr_we_,
    output logic [1:0]     ex_mem_op,
    output logic [DW-1:0]  ex_mem_wr_data,
    output logic           ex_br_flag,
    output logic [DW-1:0]  ex_data_out,
    output logic [2:0]     ex_exp_code,
    output logic [DW-1:0]  ex_fwd_data,
    output logic           ex_fwd_valid
);

    localparam int c_SHW = $clog2(DW);

    logic [DW-1:0]  w_sum;
    logic [DW-1:0]  w_diff;
    logic [DW-1:0]  w_alu_out;
    logic           w_alu_ovf;
    logic           w_md_valid;
    logic           w_md_undef;
    logic           w_md_start;
    logic           w_kill;
    logic           w_md_busy;
    logic           w_md_done;
    logic           w_md_run;
    logic [DW-1:0]  w_md_result;
    logic [DW-1:0]  w_result;

    logic           r_ex_en;
    logic [PCW-1:0] r_ex_pc;
    logic [GAW-1:0] r_ex_dst_addr;
    logic           r_ex_gpr_we_;
    mem_op_e        r_ex_mem_op;
    logic [DW-1:0]  r_ex_mem_wr_data;
    logic           r_ex_br_flag;
    logic [DW-1:0]  r_ex_data_out;
    exp_code_e      r_ex_exp_code;

    assign w_sum      = id_alu_in_0 + id_alu_in_1;
    assign w_diff     = id_alu_in_0 - id_alu_in_1;
    assign w_md_valid = md_op_valid(id_md_op);
    assign w_md_undef = (id_md_op != MD_NONE) && !w_md_valid;
    assign w_kill     = flush | int_detect;
    assign w_md_start = id_en & w_md_valid & ~w_kill;

    // ALU datapath with two's-complement overflow on the signed ops
    always_comb begin
        w_alu_out = id_alu_in_0;
        w_alu_ovf = 1'b0;
        case (alu_op_e'(id_alu_op))
            ALU_AND:  w_alu_out = id_alu_in_0 & id_alu_in_1;
            ALU_OR:   w_alu_out = id_alu_in_0 | id_alu_in_1;
            ALU_XOR:  w_alu_out = id_alu_in_0 ^ id_alu_in_1;
            ALU_ADDS: begin
                w_alu_out = w_sum;
                w_alu_ovf = (id_alu_in_0[DW-1] == id_alu_in_1[DW-1]) &&
                            (w_sum[DW-1] != id_alu_in_0[DW-1]);
            end
            ALU_ADDU: w_alu_out = w_sum;
            ALU_SUBS: begin
                w_alu_out = w_diff;
                w_alu_ovf = (id_alu_in_0[DW-1] != id_alu_in_1[DW-1]) &&
                            (w_diff[DW-1] != id_alu_in_0[DW-1]);
            end
            ALU_SUBU: w_alu_out = w_diff;
            ALU_SHRL: w_alu_out = id_alu_in_0 >> id_alu_in_1[c_SHW-1:0];
            ALU_SHLL: w_alu_out = id_alu_in_0 << id_alu_in_1[c_SHW-1:0];
            default:  w_alu_out = id_alu_in_0;
        endcase
    end

    ex_muldiv #(
        .DW       (DW)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_md_start),
        .i_op     (md_op_e'(id_md_op)),
        .i_opa    (id_alu_in_0),
        .i_opb    (id_alu_in_1),
        .i_abort  (w_kill),
        .i_ack    (~stall),
        .o_busy   (w_md_run),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    // Stall request: an MD op waiting to start, or one still iterating; forced low in reset
    always_comb begin
        w_md_busy = ~rst & ((~w_md_run & ~w_md_done & id_en & w_md_valid) | w_md_run);
    end

    assign md_busy      = w_md_busy;
    assign w_result     = w_md_done ? w_md_result : w_alu_out;
    assign ex_fwd_data  = w_result;
    assign ex_fwd_valid = id_en & ~w_md_busy;

    // EX pipeline register: reset > kill > stall > MD bubble > load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_en          <= 1'b0;
            r_ex_pc          <= '0;
            r_ex_dst_addr    <= '0;
            r_ex_gpr_we_     <= 1'b1;
            r_ex_mem_op      <= MEM_NOP;
            r_ex_mem_wr_data <= '0;
            r_ex_br_flag     <= 1'b0;
            r_ex_data_out    <= '0;
            r_ex_exp_code    <= EXP_NONE;
        end else if (w_kill || (!stall && w_md_busy)) begin
            r_ex_en       <= 1'b0;
            r_ex_gpr_we_  <= 1'b1;
            r_ex_mem_op   <= MEM_NOP;
            r_ex_exp_code <= EXP_NONE;
        end else if (!stall) begin
            r_ex_en          <= id_en;
            r_ex_pc          <= id_pc;
            r_ex_dst_addr    <= id_dst_addr;
            r_ex_mem_wr_data <= id_mem_wr_data;
            r_ex_br_flag     <= id_br_flag;
            r_ex_data_out    <= w_result;
            r_ex_gpr_we_     <= id_gpr_we_;
            r_ex_mem_op      <= mem_op_e'(id_mem_op);
            r_ex_exp_code    <= EXP_NONE;
            if (id_en && w_md_undef) begin
                r_ex_exp_code <= EXP_UNDEF_INSN;
            end else if (id_en && (id_md_op == MD_NONE) && w_alu_ovf) begin
                r_ex_exp_code <= EXP_OVERFLOW;
                r_ex_gpr_we_  <= 1'b1;
                r_ex_mem_op   <= MEM_NOP;
            end
        end
    end

    assign ex_en          = r_ex_en;
    assign ex_pc          = r_ex_pc;
    assign ex_dst_addr    = r_ex_dst_addr;
    assign ex_gpr_we_     = r_ex_gpr_we_;
    assign ex_mem_op      = r_ex_mem_op;
    assign ex_mem_wr_data = r_ex_mem_wr_data;
    assign ex_br_flag     = r_ex_br_flag;
    assign ex_data_out    = r_ex_data_out;
    assign ex_exp_code    = r_ex_exp_code;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_md.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage_md
//  Description : Directed bench for ex_stage_md: ALU vector table, mul/div
//                sequences, flush, stall-in-DONE and async reset mid-BUSY.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage_md;
    import ex_pkg::*;

    localparam int DW  = 32;
    localparam int PCW = 30;
    localparam int GAW = 5;

    logic           clk = 1'b0;
    logic           rst, stall, flush, int_detect, md_busy;
    logic           id_en, id_gpr_we_, id_br_flag;
    logic [PCW-1:0] id_pc;
    logic [3:0]     id_alu_op;
    logic [2:0]     id_md_op;
    logic [DW-1:0]  id_alu_in_0, id_alu_in_1, id_mem_wr_data;
    logic [GAW-1:0] id_dst_addr;
    logic [1:0]     id_mem_op;
    logic           ex_en, ex_gpr_we_, ex_br_flag, ex_fwd_valid;
    logic [PCW-1:0] ex_pc;
    logic [GAW-1:0] ex_dst_addr;
    logic [1:0]     ex_mem_op;
    logic [DW-1:0]  ex_mem_wr_data, ex_data_out, ex_fwd_data;
    logic [2:0]     ex_exp_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_stage_md #(.DW(DW), .PCW(PCW), .GAW(GAW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .int_detect(int_detect),
        .md_busy(md_busy), .id_en(id_en), .id_pc(id_pc), .id_alu_op(id_alu_op),
        .id_md_op(id_md_op), .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
        .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_), .id_mem_op(id_mem_op),
        .id_mem_wr_data(id_mem_wr_data), .id_br_flag(id_br_flag), .ex_en(ex_en),
        .ex_pc(ex_pc), .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_),
        .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data), .ex_br_flag(ex_br_flag),
        .ex_data_out(ex_data_out), .ex_exp_code(ex_exp_code), .ex_fwd_data(ex_fwd_data),
        .ex_fwd_valid(ex_fwd_valid)
    );

    typedef struct {
        logic [3:0]  alu;
        logic [2:0]  md;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  code;
        logic        we_;
        logic [1:0]  mem;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] alu, input logic [2:0] md,
                          input logic [31:0] a, input logic [31:0] b, input logic [29:0] pc);
        id_en = 1'b1; id_pc = pc; id_alu_op = alu; id_md_op = md;
        id_alu_in_0 = a; id_alu_in_1 = b; id_dst_addr = 5'd3; id_gpr_we_ = 1'b0;
        id_mem_op = 2'd1; id_mem_wr_data = b; id_br_flag = 1'b0;
    endtask

    task automatic drop_id();
        id_en = 1'b0; id_md_op = 3'd0; id_alu_op = 4'd0;
    endtask

    // Runs one MD op to completion and checks busy length, DONE forwarding and load
    task automatic run_md(input string nm, input logic [2:0] md, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int busy_exp);
        int n;
        set_op(4'd0, md, a, b, 30'h200);
        #1;
        n = 0;
        while (md_busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        chk({nm, " busy_cycles"}, 64'(n), 64'(busy_exp));
        chk({nm, " state_done"}, 64'(dut.u_muldiv.r_state), 64'(ST_DONE));
        chk({nm, " fwd_valid"}, 64'(ex_fwd_valid), 64'd1);
        chk({nm, " fwd_data"}, 64'(ex_fwd_data), 64'(res));
        chk({nm, " bubble_en"}, 64'(ex_en), 64'd0);
        step();
        chk({nm, " data_out"}, 64'(ex_data_out), 64'(res));
        chk({nm, " ex_en"}, 64'(ex_en), 64'd1);
        chk({nm, " state_idle"}, 64'(dut.u_muldiv.r_state), 64'(ST_IDLE));
        drop_id();
    endtask

    initial begin
        int n;
        vt[0]  = '{ALU_AND,  MD_NONE, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, EXP_NONE,       1'b0, 2'd1};
        vt[1]  = '{ALU_OR,   MD_NONE, 32'hF0000000, 32'h0000000F, 32'hF000000F, EXP_NONE,       1'b0, 2'd1};
        vt[2]  = '{ALU_XOR,  MD_NONE, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, EXP_NONE,       1'b0, 2'd1};
        vt[3]  = '{ALU_ADDS, MD_NONE, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, EXP_OVERFLOW,   1'b1, 2'd0};
        vt[4]  = '{ALU_ADDU, MD_NONE, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, EXP_NONE,       1'b0, 2'd1};
        vt[5]  = '{ALU_SUBS, MD_NONE, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, EXP_OVERFLOW,   1'b1, 2'd0};
        vt[6]  = '{ALU_SUBU, MD_NONE, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, EXP_NONE,       1'b0, 2'd1};
        vt[7]  = '{ALU_SUBS, MD_NONE, 32'h0000000A, 32'h00000003, 32'h00000007, EXP_NONE,       1'b0, 2'd1};
        vt[8]  = '{ALU_SHRL, MD_NONE, 32'h80000000, 32'h0000003F, 32'h00000001, EXP_NONE,       1'b0, 2'd1};
        vt[9]  = '{ALU_SHLL, MD_NONE, 32'h00000001, 32'h00000024, 32'h00000010, EXP_NONE,       1'b0, 2'd1};
        vt[10] = '{ALU_NOP,  MD_NONE, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, EXP_NONE,       1'b0, 2'd1};
        vt[11] = '{ALU_ADDS, MD_NONE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, EXP_NONE,       1'b0, 2'd1};
        vt[12] = '{ALU_ADDU, 3'd7,    32'h00000001, 32'h00000002, 32'h00000003, EXP_UNDEF_INSN, 1'b0, 2'd1};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; int_detect = 1'b0;
        set_op(4'd0, MD_MUL, 32'd3, 32'd4, 30'h0);
        step(); step();
        chk("rst ex_en", 64'(ex_en), 64'd0);
        chk("rst gpr_we_", 64'(ex_gpr_we_), 64'd1);
        chk("rst mem_op", 64'(ex_mem_op), 64'(MEM_NOP));
        chk("rst exp_code", 64'(ex_exp_code), 64'(EXP_NONE));
        chk("rst data_out", 64'(ex_data_out), 64'd0);
        chk("rst md_busy", 64'(md_busy), 64'd0);
        drop_id();
        rst = 1'b0;
        step();

        // ALU vector table
        for (int i = 0; i < 13; i++) begin
            set_op(vt[i].alu, vt[i].md, vt[i].a, vt[i].b, 30'(32'h100 + i));
            #1;
            chk($sformatf("vec%0d fwd_data", i), 64'(ex_fwd_data), 64'(vt[i].res));
            chk($sformatf("vec%0d fwd_valid", i), 64'(ex_fwd_valid), 64'd1);
            step();
            chk($sformatf("vec%0d data_out", i), 64'(ex_data_out), 64'(vt[i].res));
            chk($sformatf("vec%0d exp_code", i), 64'(ex_exp_code), 64'(vt[i].code));
            chk($sformatf("vec%0d gpr_we_", i), 64'(ex_gpr_we_), 64'(vt[i].we_));
            chk($sformatf("vec%0d mem_op", i), 64'(ex_mem_op), 64'(vt[i].mem));
            chk($sformatf("vec%0d ex_en", i), 64'(ex_en), 64'd1);
            chk($sformatf("vec%0d ex_pc", i), 64'(ex_pc), 64'(32'h100 + i));
        end
        drop_id();
        step();

        // Iterative mul/div
        run_md("mulhu", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_md("mul",   MD_MUL,   32'h12345678, 32'h00000010, 32'h23456780, 33);
        run_md("divu",  MD_DIVU,  32'd100,      32'd7,        32'd14,       33);
        run_md("remu",  MD_REMU,  32'd100,      32'd7,        32'd2,        33);
        run_md("divu0", MD_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_md("remu0", MD_REMU,  32'd5,        32'd0,        32'd5,        1);

        // Flush at BUSY cycle 10 of a MUL
        set_op(4'd0, MD_MUL, 32'd3, 32'd5, 30'h300);
        #1;
        chk("fl md_busy_c0", 64'(md_busy), 64'd1);
        chk("fl fwd_valid_c0", 64'(ex_fwd_valid), 64'd0);
        repeat (10) step();
        chk("fl state_busy", 64'(dut.u_muldiv.r_state), 64'(ST_BUSY));
        flush = 1'b1;
        drop_id();
        step();
        flush = 1'b0;
        chk("fl state_idle", 64'(dut.u_muldiv.r_state), 64'(ST_IDLE));
        chk("fl counter", 64'(dut.u_muldiv.r_cnt), 64'd0);
        chk("fl partial", 64'(dut.u_muldiv.r_hi), 64'd0);
        chk("fl md_busy", 64'(md_busy), 64'd0);
        chk("fl ex_en", 64'(ex_en), 64'd0);
        set_op(ALU_ADDU, MD_NONE, 32'd2, 32'd3, 30'h301);
        #1;
        chk("fl alu fwd_valid", 64'(ex_fwd_valid), 64'd1);
        step();
        chk("fl alu data_out", 64'(ex_data_out), 64'd5);
        chk("fl alu ex_en", 64'(ex_en), 64'd1);
        drop_id();

        // Stall held 5 cycles in DONE
        set_op(4'd0, MD_DIVU, 32'd100, 32'd7, 30'h400);
        #1;
        n = 0;
        while (md_busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        chk("st busy_cycles", 64'(n), 64'd33);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("st%0d state_done", k), 64'(dut.u_muldiv.r_state), 64'(ST_DONE));
            chk($sformatf("st%0d ex_en_hold", k), 64'(ex_en), 64'd0);
            chk($sformatf("st%0d data_hold", k), 64'(ex_data_out), 64'd5);
            chk($sformatf("st%0d fwd_data", k), 64'(ex_fwd_data), 64'd14);
        end
        stall = 1'b0;
        step();
        chk("st rel data_out", 64'(ex_data_out), 64'd14);
        chk("st rel ex_en", 64'(ex_en), 64'd1);
        chk("st rel state_idle", 64'(dut.u_muldiv.r_state), 64'(ST_IDLE));
        drop_id();
        step();
        chk("st once ex_en", 64'(ex_en), 64'd0);

        // Async reset in the middle of BUSY
        set_op(4'd0, MD_MUL, 32'd7, 32'd9, 30'h500);
        repeat (6) step();
        chk("ar state_busy", 64'(dut.u_muldiv.r_state), 64'(ST_BUSY));
        #2;
        rst = 1'b1;
        #1;
        chk("ar ex_en", 64'(ex_en), 64'd0);
        chk("ar ex_pc", 64'(ex_pc), 64'd0);
        chk("ar data_out", 64'(ex_data_out), 64'd0);
        chk("ar gpr_we_", 64'(ex_gpr_we_), 64'd1);
        chk("ar mem_op", 64'(ex_mem_op), 64'(MEM_NOP));
        chk("ar exp_code", 64'(ex_exp_code), 64'(EXP_NONE));
        chk("ar md_busy", 64'(md_busy), 64'd0);
        chk("ar state", 64'(dut.u_muldiv.r_state), 64'(ST_IDLE));
        chk("ar counter", 64'(dut.u_muldiv.r_cnt), 64'd0);
        chk("ar acc", 64'(dut.u_muldiv.r_hi), 64'd0);
        drop_id();
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage_md.md
EX_STAGE_MD -- requirements
Module: ex_stage_md

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning datapath/word width (>=8, even).
REQ-002 The block SHALL have parameter PCW, default 30, meaning word-address PC width.
REQ-003 The block SHALL have parameter GAW, default 5, meaning GPR address width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk in 1 (rising edge); rst in 1 (async assert, active-high).
REQ-005 The block SHALL have these pipeline-control ports: stall in 1 (hold EX register); flush in 1 (kill EX register); int_detect in 1 (interrupt; kill like flush); md_busy out 1 (stall request to IF/ID).
REQ-006 The block SHALL have these ID-side inputs: id_en 1 (valid); id_pc PCW; id_alu_op 4; id_md_op 3; id_alu_in_0 DW; id_alu_in_1 DW; id_dst_addr GAW; id_gpr_we_ 1 (active-low); id_mem_op 2; id_mem_wr_data DW; id_br_flag 1.
REQ-007 The block SHALL have these EX-register outputs: ex_en 1; ex_pc PCW; ex_dst_addr GAW; ex_gpr_we_ 1; ex_mem_op 2; ex_mem_wr_data DW; ex_br_flag 1; ex_data_out DW; ex_exp_code 3.
REQ-008 The block SHALL have these forwarding outputs: ex_fwd_data DW (combinational result of the current ID op); ex_fwd_valid 1 (ex_fwd_data usable this cycle).

Function
REQ-009 The block SHALL compute ALU ops (AND, OR, XOR, ADDS, ADDU, SUBS, SUBU, SHRL, SHLL, NOP=pass in_0) combinationally; shifts SHALL use in_1[$clog2(DW)-1:0].
REQ-010 The block SHALL flag signed overflow on ADDS/SUBS per two's-complement sign rule; when set, the loaded register SHALL have ex_exp_code=OVERFLOW, ex_gpr_we_=1 and ex_mem_op=NOP.
REQ-011 The block SHALL support id_md_op: NONE=0, MUL=1 (low DW of unsigned product), MULHU=2 (high DW), DIVU=3 (quotient), REMU=4 (remainder); other codes SHALL be treated as NONE with ex_exp_code=UNDEF_INSN.
REQ-012 The block SHALL run the mul/div FSM IDLE->BUSY->DONE->IDLE; IDLE->BUSY on id_en & md_op!=NONE & !flush & !int_detect; BUSY runs a DW-cycle iteration counter (shift-add / restoring divide, 1 bit per cycle); BUSY->DONE when counter wraps to 0; DONE->IDLE on the edge the EX register loads (DONE & !stall).
REQ-013 The block SHALL drive md_busy=1 combinationally when (IDLE & id_en & md_op!=NONE) or BUSY; md_busy=0 in DONE; ID SHALL hold id_* stable while md_busy=1.
REQ-014 The block SHALL give an MD op first presented at cycle 0 md_busy high for cycles 0..DW, load its result at the edge ending cycle DW+1 (stall=0), and show it on ex_data_out from cycle DW+2.
REQ-015 The block SHALL complete DIVU/REMU with divisor 0 without BUSY (IDLE->DONE directly), with quotient = all ones and remainder = dividend; no exception.
REQ-016 The block SHALL drive ex_fwd_valid=1 for ALU ops and in DONE, and 0 while md_busy=1.
REQ-017 The block SHALL update the EX register with priority rst > flush|int_detect > stall > md_busy > load, where flush|int_detect gives ex_en=0, ex_gpr_we_=1, ex_mem_op=NOP, ex_exp_code=NONE; stall holds all fields; md_busy=1 gives a bubble like flush; load copies id_* plus the result (ALU or MD).
REQ-018 On flush or int_detect in any FSM state, the block SHALL return the FSM to IDLE at the next edge, zero the counter, and discard the partial result.
REQ-019 The block SHALL keep the FSM in DONE and preserve the result while stall=1 is held.

Reset
REQ-020 On rst=1 the block SHALL asynchronously clear ex_en, ex_pc, ex_dst_addr, ex_mem_wr_data, ex_data_out, ex_br_flag, counter and MD operand/accumulator registers to 0, set ex_gpr_we_=1, ex_mem_op=NOP, ex_exp_code=NONE and FSM=IDLE; md_busy SHALL be 0 during reset.

Structure
REQ-021 Package ex_pkg SHALL hold alu_op_e, md_op_e, mem_op_e, exp_code_e (NONE, UNDEF_INSN, OVERFLOW, ...) and md_state_e.
REQ-022 The iterative unit SHALL be sub-module ex_muldiv (start/op/operands in; busy, done, result out; abort in), with the ALU and EX register in ex_stage_md.

Verification
REQ-023 The bench SHALL check ADDS 0x7FFFFFFF+1: next cycle ex_exp_code=OVERFLOW, ex_gpr_we_=1; ADDU same operands gives ex_data_out=0x80000000, exp NONE.
REQ-024 The bench SHALL check MULHU 0xFFFFFFFF*0xFFFFFFFF: md_busy high 33 cycles, then ex_data_out=0xFFFFFFFE, ex_en=1.
REQ-025 The bench SHALL check DIVU 100/7 -> 14 and REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF with md_busy high exactly 1 cycle.
REQ-026 The bench SHALL check flush at BUSY cycle 10 of a MUL: next cycle FSM IDLE, md_busy=0, ex_en=0; a following ALU op completes in 1 cycle.
REQ-027 The bench SHALL check stall=1 for 5 cycles in DONE: ex_* hold, DONE held; on release the result loads once and the FSM returns to IDLE.
REQ-028 The bench SHALL check rst asserted mid-BUSY: outputs immediately take REQ-020 values without waiting for clk.
